regram_fifo: RTL and testbench
==============================

# regram_fifo

Synchronous first-in-first-out queue controller built directly on top of the team's 0-latency register RAM (`sync_regram`). It owns the read/write pointers, occupancy tracking and valid/ready handshakes, and drives an external `sync_regram` instance through dedicated RAM-side ports. It is the standard way pipeline stages buffer requests (e.g. store buffers, refill queues) without hand-rolling pointer logic.

## Interface
- `DATA_WIDTH`, 32: payload width in bits; must match the attached RAM.
- `DATA_DEPTH`, 8: entry count; power of two, ≥ 2; must match the attached RAM.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous queue clear.
- `inp_valid_i`  in  1  push request.
- `inp_ready_o`  out  1  push accepted when high with `inp_valid_i`.
- `inp_data_i`  in  DATA_WIDTH  push payload.
- `oup_valid_o`  out  1  head entry present.
- `oup_ready_i`  in  1  consumer takes head when high with `oup_valid_o`.
- `oup_data_o`  out  DATA_WIDTH  head payload.
- `count_o`  out  $clog2(DATA_DEPTH)+1  current occupancy, 0..DATA_DEPTH.
- `ram_waddr_o`  out  $clog2(DATA_DEPTH)  RAM write address (= write pointer low bits).
- `ram_we_o`  out  1  RAM write enable.
- `ram_wdata_o`  out  DATA_WIDTH  RAM write data (= `inp_data_i`).
- `ram_raddr_o`  out  $clog2(DATA_DEPTH)  RAM read address (= read pointer low bits).
- `ram_rdata_i`  in  DATA_WIDTH  RAM read data, combinational from `ram_raddr_o`.

## Operation
- State: `wptr`, `rptr`, each $clog2(DATA_DEPTH)+1 bits (extra wrap bit); no separate counter register.
- empty = (`wptr == rptr`); full = low bits equal and wrap bits differ.
- `count_o` = `wptr - rptr` modulo 2^($clog2(DATA_DEPTH)+1).
- `inp_ready_o` = ~full & ~`flush_i`. No full-pop-push pass-through: when full, push is refused even if a pop happens that cycle.
- `oup_valid_o` = ~empty. No empty bypass: a pushed entry is never visible in its push cycle.
- `oup_data_o` = `ram_rdata_i` (head read combinationally via `ram_raddr_o` = `rptr` low bits).
- push = `inp_valid_i` & `inp_ready_o`; `ram_we_o` = push; on push, `wptr` += 1.
- pop = `oup_valid_o` & `oup_ready_i` & ~`flush_i`; on pop, `rptr` += 1.
- Simultaneous push and pop (non-full, non-empty): both pointers advance; count unchanged.
- Pointer wrap: low bits roll DATA_DEPTH-1 → 0, wrap bit toggles.
- `flush_i` high: `ram_we_o` forced 0, no push/pop counted; next edge `wptr`/`rptr` ← 0. RAM contents untouched.
- Reset (async assert): `wptr`, `rptr` ← 0 immediately. Outputs during/after reset: `oup_valid_o`=0, `inp_ready_o`=1 (unless flush), `count_o`=0, `ram_we_o`=0 when `inp_valid_i`=0, addresses 0. Reset mid-traffic drops all entries.
- Deassertion of `rst_n` assumed synchronized externally; block adds no synchronizer.

## Timing
- Push → visible at output: 1 cycle (written at edge N, `oup_valid_o` high in cycle N+1).
- Pop → next head on `oup_data_o`: same cycle after edge (0-latency RAM read).
- `inp_ready_o`, `oup_valid_o`, `count_o` depend only on registered pointers plus `flush_i`; no combinational path from `inp_valid_i` or `oup_ready_i` to any ready/valid output.
- `ram_we_o` and `ram_wdata_o` combinational from `inp_valid_i`/`inp_data_i`.
- Max throughput: one push and one pop per cycle.

## Test plan
- Reset, then push 0xA0..0xA7 on consecutive cycles (DEPTH=8) with `oup_ready_i`=0 → `count_o` 1..8, `inp_ready_o`=0 after 8th; 9th push 0xA8 refused, `ram_we_o`=0.
- From full, hold `inp_valid_i`=1 (0xB0) and `oup_ready_i`=1 → first cycle pops 0xA0, push refused; next cycle push accepted; pop order 0xA0..0xA7 then 0xB0.
- Streaming push+pop every cycle for 20 cycles from count 3 → `count_o` constant 3, data in-order across pointer wrap (`ram_waddr_o` 7→0).
- Empty FIFO, push 0x55 at edge N → `oup_valid_o`=0 in push cycle, =1 with `oup_data_o`=0x55 in N+1.
- Count 5, assert `flush_i` with `inp_valid_i`=1 and `oup_ready_i`=1 → `ram_we_o`=0, next cycle `count_o`=0, `oup_valid_o`=0.
- Count 4, assert `rst_n`=0 mid-cycle (between edges) → `count_o`=0 and `oup_valid_o`=0 immediately, before next clock edge.

Source files
------------

// File: rtl/regram_fifo_if.sv
// Handshake and RAM-side signal bundle for regram_fifo.
// slave = the FIFO controller, master = producer/consumer/RAM side.
interface regram_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8
);
  localparam int AW = $clog2(DATA_DEPTH);

  logic                  flush_i;
  logic                  inp_valid_i;
  logic                  inp_ready_o;
  logic [DATA_WIDTH-1:0] inp_data_i;
  logic                  oup_valid_o;
  logic                  oup_ready_i;
  logic [DATA_WIDTH-1:0] oup_data_o;
  logic [AW:0]           count_o;
  logic [AW-1:0]         ram_waddr_o;
  logic                  ram_we_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic [AW-1:0]         ram_raddr_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;

  modport slave (
    input  flush_i, inp_valid_i, inp_data_i, oup_ready_i, ram_rdata_i,
    output inp_ready_o, oup_valid_o, oup_data_o, count_o,
           ram_waddr_o, ram_we_o, ram_wdata_o, ram_raddr_o
  );

  modport master (
    output flush_i, inp_valid_i, inp_data_i, oup_ready_i, ram_rdata_i,
    input  inp_ready_o, oup_valid_o, oup_data_o, count_o,
           ram_waddr_o, ram_we_o, ram_wdata_o, ram_raddr_o
  );
endinterface

// File: rtl/regram_fifo.sv
// FIFO pointer/occupancy controller driving an external 0-latency register RAM.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module regram_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    regram_fifo_if.slave bus
);
    localparam int AW = $clog2(DATA_DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    // Handshake: a beat transfers on a cycle where valid and ready are both high.
    // Ready/valid outputs depend only on the pointers and flush_i, never on the peer's
    // valid/ready, and a full FIFO refuses a push even if it pops in the same cycle.
    assign bus.inp_ready_o = ~full & ~bus.flush_i;
    assign bus.oup_valid_o = ~empty;

    assign push = bus.inp_valid_i & bus.inp_ready_o;
    assign pop  = bus.oup_valid_o & bus.oup_ready_i & ~bus.flush_i;

    assign bus.ram_we_o    = push;
    assign bus.ram_waddr_o = wptr[AW-1:0];
    assign bus.ram_wdata_o = bus.inp_data_i;
    assign bus.ram_raddr_o = rptr[AW-1:0];
    assign bus.oup_data_o  = bus.ram_rdata_i;
    assign bus.count_o     = wptr - rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (bus.flush_i) begin
            // RAM contents are left as-is; only the pointers are cleared.
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_regram_fifo.sv
// Directed bench for regram_fifo with a behavioural register RAM and an expected-data queue.
module tb_regram_fifo;
  localparam int DW = 32;
  localparam int DD = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [DD];

  regram_fifo_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) bus ();

  regram_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0-latency register RAM: registered write, combinational read
  always_ff @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_waddr_o] <= bus.ram_wdata_o;
  end
  assign bus.ram_rdata_i = mem[bus.ram_raddr_o];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // single push cycle with the consumer idle
  task automatic push_one(input logic [DW-1:0] d);
    bus.inp_valid_i = 1'b1;
    bus.inp_data_i  = d;
    bus.oup_ready_i = 1'b0;
    #1;
    check("push_we", {31'b0, bus.ram_we_o}, 32'd1);
    exp_q.push_back(d);
    tick();
    bus.inp_valid_i = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_wa;
    bit         b0_done;
    bit         pushed;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.flush_i     = 1'b0;
    bus.inp_valid_i = 1'b0;
    bus.inp_data_i  = '0;
    bus.oup_ready_i = 1'b0;
    for (int i = 0; i < DD; i++) mem[i] = '0;

    // reset state
    #3;
    check("rst_count", {28'b0, bus.count_o}, 32'd0);
    check("rst_oup_valid", {31'b0, bus.oup_valid_o}, 32'd0);
    check("rst_inp_ready", {31'b0, bus.inp_ready_o}, 32'd1);
    check("rst_we", {31'b0, bus.ram_we_o}, 32'd0);
    check("rst_waddr", {29'b0, bus.ram_waddr_o}, 32'd0);
    check("rst_raddr", {29'b0, bus.ram_raddr_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // fill 0xA0..0xA7
    for (int i = 0; i < DD; i++) begin
      bus.inp_valid_i = 1'b1;
      bus.inp_data_i  = 32'hA0 + i;
      #1;
      check("fill_ready", {31'b0, bus.inp_ready_o}, 32'd1);
      check("fill_we", {31'b0, bus.ram_we_o}, 32'd1);
      check("fill_waddr", {29'b0, bus.ram_waddr_o}, i);
      exp_q.push_back(32'hA0 + i);
      tick();
      check("fill_count", {28'b0, bus.count_o}, i + 1);
    end
    bus.inp_data_i = 32'hA8;
    #1;
    check("full_ready", {31'b0, bus.inp_ready_o}, 32'd0);
    check("full_we_refused", {31'b0, bus.ram_we_o}, 32'd0);
    tick();
    check("full_count_hold", {28'b0, bus.count_o}, 32'd8);

    // drain from full while offering 0xB0
    b0_done = 1'b0;
    bus.inp_data_i  = 32'hB0;
    bus.oup_ready_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.inp_valid_i = !b0_done;
      #1;
      if (c == 0) check("drain_ready_full", {31'b0, bus.inp_ready_o}, 32'd0);
      if (c == 1) check("drain_ready_free", {31'b0, bus.inp_ready_o}, 32'd1);
      check("drain_valid", {31'b0, bus.oup_valid_o}, 32'd1);
      check("drain_data", bus.oup_data_o, exp_q[0]);
      pushed = bus.inp_valid_i && bus.inp_ready_o;
      tick();
      void'(exp_q.pop_front());
      if (pushed) begin
        exp_q.push_back(32'hB0);
        b0_done = 1'b1;
      end
    end
    bus.inp_valid_i = 1'b0;
    bus.oup_ready_i = 1'b0;
    check("drain_b0_done", {31'b0, b0_done}, 32'd1);
    check("drain_count", {28'b0, bus.count_o}, 32'd0);
    check("drain_valid_end", {31'b0, bus.oup_valid_o}, 32'd0);

    // push into empty: not visible until the following cycle (pointers now at 9)
    bus.inp_valid_i = 1'b1;
    bus.inp_data_i  = 32'h55;
    #1;
    check("nobypass_valid", {31'b0, bus.oup_valid_o}, 32'd0);
    exp_q.push_back(32'h55);
    tick();
    bus.inp_valid_i = 1'b0;
    #1;
    check("visible_valid", {31'b0, bus.oup_valid_o}, 32'd1);
    check("visible_data", bus.oup_data_o, 32'h55);
    check("visible_count", {28'b0, bus.count_o}, 32'd1);
    push_one(32'h60);
    push_one(32'h61);

    // streaming push+pop at count 3; write pointer starts at 12 (low bits 4)
    exp_wa = 3'd4;
    bus.inp_valid_i = 1'b1;
    bus.oup_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.inp_data_i = 32'hC0 + i;
      #1;
      check("stream_count", {28'b0, bus.count_o}, 32'd3);
      check("stream_data", bus.oup_data_o, exp_q[0]);
      check("stream_waddr", {29'b0, bus.ram_waddr_o}, {29'b0, exp_wa});
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'hC0 + i);
      exp_wa = exp_wa + 3'd1;
    end
    bus.inp_valid_i = 1'b0;
    bus.oup_ready_i = 1'b0;
    #1;
    check("stream_count_end", {28'b0, bus.count_o}, 32'd3);
    check("stream_head", bus.oup_data_o, 32'hD1);

    // flush at count 5 with both sides active
    push_one(32'hD0);
    push_one(32'hD1);
    #1;
    check("preflush_count", {28'b0, bus.count_o}, 32'd5);
    bus.flush_i     = 1'b1;
    bus.inp_valid_i = 1'b1;
    bus.oup_ready_i = 1'b1;
    bus.inp_data_i  = 32'hEE;
    #1;
    check("flush_we", {31'b0, bus.ram_we_o}, 32'd0);
    check("flush_ready", {31'b0, bus.inp_ready_o}, 32'd0);
    tick();
    bus.flush_i     = 1'b0;
    bus.inp_valid_i = 1'b0;
    bus.oup_ready_i = 1'b0;
    exp_q.delete();
    #1;
    check("flush_count", {28'b0, bus.count_o}, 32'd0);
    check("flush_valid", {31'b0, bus.oup_valid_o}, 32'd0);

    // reset mid-cycle at count 4
    for (int i = 0; i < 4; i++) push_one(32'hE0 + i);
    #1;
    check("prerst_count", {28'b0, bus.count_o}, 32'd4);
    check("prerst_data", bus.oup_data_o, 32'hE0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_count", {28'b0, bus.count_o}, 32'd0);
    check("midrst_valid", {31'b0, bus.oup_valid_o}, 32'd0);
    check("midrst_ready", {31'b0, bus.inp_ready_o}, 32'd1);
    check("midrst_raddr", {29'b0, bus.ram_raddr_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postrst_count", {28'b0, bus.count_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
